edge_pulse_array: RTL and testbench

Parametrised array of debounced edge-to-pulse converters for asynchronous push-button and switch inputs, with selectable edge mode and auto-repeat. Each of N channels synchronises its input, debounces it over a programmable number of cycles, and emits a one-cycle pulse on the selected edge. Channels held active can emit repeat pulses. The block sits between board-level inputs and the control FSMs, where it supplies clean, single-cycle strobes.

---
 rtl/edge_pulse_array.sv | 96 +++++++++
 tb/tb_edge_pulse_array.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/edge_pulse_array.sv
// N-channel debounced edge-to-pulse converter with global edge select and optional auto-repeat.
// Each channel: 2-flop synchroniser, stability-count debouncer, registered one-cycle strobe.
module edge_pulse_array #(
    parameter int N             = 18,
    parameter int DEBOUNCE      = 4,
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] in,
    input  logic [1:0]   mode,
    output logic [N-1:0] q,
    output logic [N-1:0] level,
    output logic         any
);

    localparam int DC_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RC_W   = $clog2(RC_MAX + 1);
    localparam bit REPEAT_EN = (REPEAT_DELAY > 0);

    localparam logic [DC_W-1:0] DC_LAST   = DC_W'(DEBOUNCE - 1);
    localparam logic [RC_W-1:0] RC_DELAY  = RC_W'(REPEAT_DELAY);
    localparam logic [RC_W-1:0] RC_PERIOD = RC_W'(REPEAT_PERIOD);
    localparam logic [RC_W-1:0] RC_ONE    = RC_W'(1);

    logic [N-1:0] r_s1;
    logic [N-1:0] r_s2;
    logic [N-1:0] r_level;
    logic [N-1:0] r_q;
    logic         r_any;

    logic [N-1:0] w_flip;
    logic [N-1:0] w_rep;
    logic [N-1:0] w_q_next;
    logic         w_rise_ok;
    logic         w_fall_ok;

    assign w_rise_ok = (mode == 2'b00) || (mode == 2'b10);
    assign w_fall_ok = (mode == 2'b01) || (mode == 2'b10);

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_ch
            logic [DC_W-1:0] r_dc;
            logic [RC_W-1:0] r_rc;

            assign w_flip[g] = (r_s2[g] != r_level[g]) && (r_dc == DC_LAST);
            // A fall flip cancels repeating, so it wins over a repeat due in the same cycle.
            assign w_rep[g]  = REPEAT_EN && r_level[g] && !w_flip[g] && (r_rc == RC_ONE);
            assign w_q_next[g] = (w_flip[g] && (r_s2[g] ? w_rise_ok : w_fall_ok))
                               || (w_rep[g] && w_rise_ok);

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_dc <= '0;
                    r_rc <= '0;
                end else begin
                    if ((r_s2[g] == r_level[g]) || w_flip[g])
                        r_dc <= '0;
                    else
                        r_dc <= r_dc + DC_W'(1);

                    if (!REPEAT_EN)
                        r_rc <= '0;
                    else if (w_flip[g])
                        r_rc <= r_s2[g] ? RC_DELAY : '0;
                    else if (r_level[g] && (r_rc != '0))
                        r_rc <= (r_rc == RC_ONE) ? RC_PERIOD : (r_rc - RC_ONE);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_level <= '0;
            r_q     <= '0;
            r_any   <= 1'b0;
        end else begin
            r_s1    <= in;
            r_s2    <= r_s1;
            r_level <= r_level ^ w_flip;
            r_q     <= w_q_next;
            r_any   <= |w_q_next;
        end
    end

    assign q     = r_q;
    assign level = r_level;
    assign any   = r_any;

endmodule

// File: tb/tb_edge_pulse_array.sv
// Bench for edge_pulse_array: vector table, hand-timed corner sequences and a
// random phase, all checked against a cycle-level reference model.
module tb_edge_pulse_array;

    localparam int NCH = 4;
    localparam int DEB = 3;
    localparam int RD  = 10;
    localparam int RP  = 4;

    logic             clk     = 1'b0;
    logic             t_reset = 1'b1;
    logic [NCH-1:0]   t_in    = '0;
    logic [1:0]       t_mode  = 2'b00;
    logic [NCH-1:0]   q;
    logic [NCH-1:0]   level;
    logic             any;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    edge_pulse_array #(
        .N(NCH), .DEBOUNCE(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(t_reset), .in(t_in), .mode(t_mode),
        .q(q), .level(level), .any(any)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic rise_ok(input logic [1:0] m);
        return (m == 2'b00) || (m == 2'b10);
    endfunction

    function automatic logic fall_ok(input logic [1:0] m);
        return (m == 2'b01) || (m == 2'b10);
    endfunction

    // Reference model: level flips once the last DEB synchronised samples all
    // disagree with it; repeats fall on a fixed grid measured from the rise.
    logic [NCH-1:0] m_s1 = '0, m_s2 = '0, m_level = '0, exp_q_v = '0, m_qn;
    logic           exp_any = 1'b0;
    logic [DEB-1:0] m_hist [NCH];
    int             m_t_rise [NCH];
    int             cyc = 0;

    always @(posedge clk) begin
        if (t_reset) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; exp_q_v = '0; exp_any = 1'b0;
            for (int ch = 0; ch < NCH; ch++) m_hist[ch] = '0;
        end else begin
            m_qn = '0;
            for (int ch = 0; ch < NCH; ch++) begin
                m_hist[ch] = {m_hist[ch][DEB-2:0], m_s2[ch]};
                if (m_hist[ch] == {DEB{~m_level[ch]}}) begin
                    m_level[ch] = ~m_level[ch];
                    if (m_level[ch]) begin
                        m_qn[ch] = rise_ok(t_mode);
                        m_t_rise[ch] = cyc;
                    end else begin
                        m_qn[ch] = fall_ok(t_mode);
                    end
                end else if (RD > 0 && m_level[ch] && (cyc - m_t_rise[ch]) >= RD
                             && ((cyc - m_t_rise[ch] - RD) % RP) == 0) begin
                    m_qn[ch] = rise_ok(t_mode);
                end
            end
            exp_q_v = m_qn;
            exp_any = |m_qn;
            m_s2 = m_s1;
            m_s1 = t_in;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) check("model", {q, level, any}, {exp_q_v, m_level, exp_any});
    end

    typedef struct {
        logic [NCH-1:0] pat;
        logic [1:0]     mode;
        logic [7:0]     exp_cnt;   // 2 bits per channel, ch3..ch0
        int             exp_any;
    } vec_t;

    vec_t           vt [6];
    int             cnt [NCH];
    int             acnt, w, np, lv;
    logic [7:0]     act_cnt;
    logic [7:0]     exp_q [$];
    logic [7:0]     got_q [$];
    int             idx;

    initial begin
        vt[0] = '{4'b0100, 2'b00, 8'b00_01_00_00, 1};
        vt[1] = '{4'b0001, 2'b01, 8'b00_00_00_01, 1};
        vt[2] = '{4'b1001, 2'b10, 8'b10_00_00_10, 2};
        vt[3] = '{4'b0110, 2'b11, 8'b00_00_00_00, 0};
        vt[4] = '{4'b1111, 2'b00, 8'b01_01_01_01, 1};
        vt[5] = '{4'b1010, 2'b01, 8'b01_00_01_00, 1};

        t_reset = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_q", q, 0);
        check("reset_level", level, 0);
        check("reset_any", any, 0);
        t_reset = 1'b0;

        // Table: press pattern for 8 cycles, release for 8, count pulses.
        for (int i = 0; i < 6; i++) begin
            t_mode = vt[i].mode;
            t_in   = vt[i].pat;
            acnt   = 0;
            for (int ch = 0; ch < NCH; ch++) cnt[ch] = 0;
            for (int c = 0; c < 16; c++) begin
                if (c == 8) begin
                    check("vec_level_pressed", level, vt[i].pat);
                    t_in = '0;
                end
                @(negedge clk);
                for (int ch = 0; ch < NCH; ch++) if (q[ch]) cnt[ch]++;
                if (any) acnt++;
            end
            check("vec_level_released", level, 0);
            for (int ch = 0; ch < NCH; ch++) act_cnt[2*ch +: 2] = cnt[ch][1:0];
            check("vec_pulse_count", act_cnt, vt[i].exp_cnt);
            check("vec_any_count", acnt, vt[i].exp_any);
        end

        // Single press: exact latency, then the first repeat.
        t_mode = 2'b00;
        t_in   = 4'b0100;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            check("press_q", q, (c == 5 || c == 15) ? 4'b0100 : 4'b0000);
            check("press_any", any, (c == 5 || c == 15) ? 1 : 0);
            check("press_level", level, (c >= 5) ? 4'b0100 : 4'b0000);
        end
        t_in = '0;
        repeat (12) @(negedge clk);

        // Auto-repeat spacing on channel 1.
        t_in = 4'b0010;
        w = 0;
        do begin @(negedge clk); w++; end while (q[1] !== 1'b1 && w < 20);
        check("rep_edge_latency", w, 5);
        exp_q = '{8'd10, 8'd14, 8'd18, 8'd22, 8'd26};
        got_q.delete();
        for (int off = 1; off <= 28; off++) begin
            @(negedge clk);
            if (q[1]) got_q.push_back(8'(off));
        end
        check("rep_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check("rep_offset", (i < got_q.size()) ? got_q[i] : 8'hff, exp_q[i]);
        t_in = '0;
        repeat (10) @(negedge clk);
        np = 0;
        repeat (20) begin @(negedge clk); if (q[1]) np++; end
        check("rep_after_release", np, 0);

        // Bounce rejection on channel 0: 2-high/1-low chatter, then a solid press.
        np = 0; lv = 0;
        for (int c = 0; c < 21; c++) begin
            t_in[0] = ((c % 3) != 2);
            @(negedge clk);
            if (q[0]) np++;
            if (level[0]) lv++;
        end
        check("bounce_no_pulse", np, 0);
        check("bounce_level_still", lv, 0);
        t_in[0] = 1'b1;
        w = 0;
        do begin @(negedge clk); w++; end while (q[0] !== 1'b1 && w < 12);
        check("bounce_final_latency", w, 5);
        check("bounce_level_set", level[0], 1);
        t_in = '0;
        repeat (12) @(negedge clk);

        // Reset while ch1 has rc=5 and ch3 has dc=2.
        t_in = 4'b0010;
        w = 0;
        do begin @(negedge clk); w++; end while (q[1] !== 1'b1 && w < 20);
        check("rst_edge_latency", w, 5);
        @(negedge clk);
        t_in[3] = 1'b1;
        repeat (4) @(negedge clk);
        t_reset = 1'b1;
        @(negedge clk);
        check("rst_q", q, 0);
        check("rst_level", level, 0);
        check("rst_any", any, 0);
        t_reset = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            check("rst_fresh_q", q, (c == 5) ? 4'b1010 : 4'b0000);
            check("rst_fresh_any", any, (c == 5) ? 1 : 0);
        end
        t_in = '0;
        repeat (12) @(negedge clk);

        // Random phase: fast chatter first, then slower presses long enough to repeat.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, (c < 1500) ? 3 : 24) == 0) begin
                idx = $urandom_range(0, NCH - 1);
                t_in[idx] = ~t_in[idx];
            end
            if ($urandom_range(0, 99) == 0) t_mode = 2'($urandom_range(0, 3));
            t_reset = ($urandom_range(0, 399) == 0);
        end
        t_reset = 1'b0;
        t_in = '0;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
